// File: rtl/vmm_pkg.sv
// Shared types and width helpers for the vector modular multiplier.
package vmm_pkg;

    localparam int unsigned VMM_N = 8;
    localparam int unsigned VMM_R = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vmm_state_t;

    function automatic int unsigned acc_w(input int unsigned n);
        return n + 2;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ACC_W = acc_w(VMM_N);
    localparam int unsigned CNT_W = cnt_w(VMM_N);

endpackage

// File: rtl/vmm_lane.sv
// One lane of the interleaved modular multiplier: P = reduce(2P + abit*b) per enable.
module vmm_lane
    import vmm_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = acc_w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         abit,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    output logic [N-1:0] p
);

    logic [AW-1:0] acc;
    logic [AW-1:0] dbl;
    logic [AW-1:0] sum;
    logic [AW-1:0] red1;
    logic [AW-1:0] red2;

    // 2P + b < 3M, so two conditional subtractions bring P back below M
    always_comb begin
        dbl  = acc << 1;
        sum  = abit ? dbl + AW'(b) : dbl;
        red1 = (sum  >= AW'(m)) ? sum  - AW'(m) : sum;
        red2 = (red1 >= AW'(m)) ? red1 - AW'(m) : red1;
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= red2;
        end
    end

    assign p = acc[N-1:0];

endmodule

// File: rtl/vec_modmul_unit.sv
// R-lane (A*B) mod M unit, one multiplier bit per negedge, stalls the pipeline while running.
// Optional build macro VMM_ERR_CHECK_EN adds per-lane LaneErr flags.
module vec_modmul_unit
    import vmm_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned R = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [R-1:0][N-1:0] A,
    input  logic [R-1:0][N-1:0] B,
    input  logic [N-1:0]        M,
    input  logic [3:0]          WA3In,
    output logic                busy,
    output logic                done,
    output logic [R-1:0][N-1:0] Result,
    output logic [3:0]          WA3Out,
    output logic                RegWriteOut
`ifdef VMM_ERR_CHECK_EN
    ,
    output logic [R-1:0]        LaneErr
`endif
);

    localparam int unsigned AW = acc_w(N);
    localparam int unsigned CW = cnt_w(N);

    vmm_state_t state, state_nxt;

    logic [CW-1:0]        cnt;
    logic [R-1:0][N-1:0]  a_q;
    logic [R-1:0][N-1:0]  b_q;
    logic [N-1:0]         m_q;
    logic [3:0]           tag_q;
    logic [R-1:0][N-1:0]  lane_res;
    logic [R-1:0][N-1:0]  res_q;
    logic [R-1:0]         lane_zero;
    logic [N-1:0]         lane_p [R];
    logic                 accept;
    logic                 step;
    logic                 finish;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign RegWriteOut = done;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            tag_q  <= '0;
            res_q  <= '0;
            WA3Out <= '0;
`ifdef VMM_ERR_CHECK_EN
            LaneErr <= '0;
`endif
        end else begin
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                m_q   <= M;
                tag_q <= WA3In;
                cnt   <= CW'(N - 1);
`ifdef VMM_ERR_CHECK_EN
                for (int unsigned i = 0; i < R; i++) begin
                    LaneErr[i] <= (M == '0) || (B[i] >= M);
                end
`endif
            end else if (step && !finish) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                WA3Out <= tag_q;
            end
            if (done) begin
                res_q <= lane_res;
            end
        end
    end

    for (genvar g = 0; g < R; g++) begin : g_lane
        vmm_lane #(
            .N  (N),
            .AW (AW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (accept),
            .en    (step),
            .abit  (a_q[g][cnt]),
            .b     (b_q[g]),
            .m     (m_q),
            .p     (lane_p[g])
        );
    end

    always_comb begin
        lane_zero = '0;
        lane_res  = '0;
        for (int unsigned i = 0; i < R; i++) begin
            lane_zero[i] = (m_q == '0);
`ifdef VMM_ERR_CHECK_EN
            lane_zero[i] = lane_zero[i] | LaneErr[i];
`endif
            lane_res[i] = lane_zero[i] ? '0 : lane_p[i];
        end
    end

    // Lanes hold the final P during DONE; res_q captures it so Result persists after the lanes clear
    assign Result = (state == DONE) ? lane_res : res_q;

endmodule

// File: tb/tb_vec_modmul_unit.sv
// Scoreboard testbench for vec_modmul_unit (state changes on negedge; bench drives/samples on posedge).
module tb_vec_modmul_unit;

    localparam int N = 8;
    localparam int R = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [R-1:0][N-1:0] A, B, Result;
    logic [N-1:0]        M;
    logic [3:0]          WA3In, WA3Out;
    logic                busy, done, RegWriteOut;
`ifdef VMM_ERR_CHECK_EN
    logic [R-1:0]        LaneErr;
`endif

    always #5 clk = ~clk;

    vec_modmul_unit #(.N(N), .R(R)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .M           (M),
        .WA3In       (WA3In),
        .busy        (busy),
        .done        (done),
        .Result      (Result),
        .WA3Out      (WA3Out),
        .RegWriteOut (RegWriteOut)
`ifdef VMM_ERR_CHECK_EN
        ,
        .LaneErr     (LaneErr)
`endif
    );

    typedef struct {
        logic [R-1:0][N-1:0] res;
        logic [3:0]          tag;
        logic [R-1:0]        err;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic exp_t model(input logic [R-1:0][N-1:0] a, input logic [R-1:0][N-1:0] b,
                                   input logic [N-1:0] m, input logic [3:0] tag);
        exp_t e;
        int unsigned pr;
        e.tag = tag;
        for (int i = 0; i < R; i++) begin
            e.err[i] = (m == 0) || (b[i] >= m);
            if (m == 0) begin
                e.res[i] = '0;
            end else begin
                pr = (int'(a[i]) * int'(b[i])) % int'(m);
                e.res[i] = N'(pr);
            end
`ifdef VMM_ERR_CHECK_EN
            if (e.err[i]) e.res[i] = '0;
`endif
        end
        return e;
    endfunction

    task automatic issue(input logic [R-1:0][N-1:0] a, input logic [R-1:0][N-1:0] b,
                         input logic [N-1:0] m, input logic [3:0] tag);
        A = a; B = b; M = m; WA3In = tag; start = 1'b1;
        sb.push_back(model(a, b, m, tag));
    endtask

    // Waits for the accepting negedge, then counts posedge samples until done (or budget expires).
    task automatic wait_done(output int bc, output int da);
        bc = 0; da = -1;
        @(negedge clk);
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            if (j == 1) start = 1'b0;
            if (busy) bc++;
            if (done) begin da = j; break; end
        end
    endtask

    function automatic logic [R-1:0][N-1:0] rand_vec(input int unsigned hi);
        logic [R-1:0][N-1:0] v;
        for (int i = 0; i < R; i++) v[i] = N'($urandom_range(0, hi));
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; A = '0; B = '0; M = '0; WA3In = '0;
        repeat (3) @(posedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (RegWriteOut !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWriteOut); end
        n_checks++; if (Result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", Result); end
        n_checks++; if (WA3Out !== 4'h0) begin n_fail++; $display("FAIL reset_wa3: got %h want 0", WA3Out); end
`ifdef VMM_ERR_CHECK_EN
        n_checks++; if (LaneErr !== '0) begin n_fail++; $display("FAIL reset_laneerr: got %b want 0", LaneErr); end
`endif
        reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_basic();
        logic [R-1:0][N-1:0] a, b;
        exp_t e;
        int bc, da;
        a = rand_vec(255); b = rand_vec(12);
        a[0] = 8'd7; b[0] = 8'd5;
        issue(a, b, 8'd13, 4'hA);
        wait_done(bc, da);
        e = sb.pop_front();
        n_checks++; if (da !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", da); end
        n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        n_checks++; if (Result !== e.res) begin n_fail++; $display("FAIL basic_result: got %h want %h", Result, e.res); end
        n_checks++; if (Result[0] !== 8'd9) begin n_fail++; $display("FAIL basic_lane0: got %0d want 9", Result[0]); end
        n_checks++; if (WA3Out !== e.tag) begin n_fail++; $display("FAIL basic_wa3: got %h want %h", WA3Out, e.tag); end
        n_checks++; if (RegWriteOut !== 1'b1) begin n_fail++; $display("FAIL basic_regwrite: got %b want 1", RegWriteOut); end
        repeat (2) @(posedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_checks++; if (Result !== e.res) begin n_fail++; $display("FAIL basic_result_hold: got %h want %h", Result, e.res); end
        n_checks++; if (WA3Out !== e.tag) begin n_fail++; $display("FAIL basic_wa3_hold: got %h want %h", WA3Out, e.tag); end
    endtask

    task automatic test_lanes();
        logic [R-1:0][N-1:0] a, b;
        exp_t e;
        int bc, da;
        a = rand_vec(255); b = rand_vec(250);
        a[0] = 8'd255; b[0] = 8'd200;
        a[1] = 8'd0;   b[1] = 8'd9;
        a[2] = 8'd250; b[2] = 8'd250;
        issue(a, b, 8'd251, 4'h3);
        wait_done(bc, da);
        e = sb.pop_front();
        n_checks++; if (da !== 9) begin n_fail++; $display("FAIL lanes_latency: got %0d want 9", da); end
        n_checks++; if (Result !== e.res) begin n_fail++; $display("FAIL lanes_result: got %h want %h", Result, e.res); end
        n_checks++; if (Result[0] !== 8'd47) begin n_fail++; $display("FAIL lanes_l0: got %0d want 47", Result[0]); end
        n_checks++; if (Result[1] !== 8'd0) begin n_fail++; $display("FAIL lanes_l1: got %0d want 0", Result[1]); end
        n_checks++; if (Result[2] !== 8'd1) begin n_fail++; $display("FAIL lanes_l2: got %0d want 1", Result[2]); end
        @(posedge clk);
    endtask

    task automatic test_modulus();
        exp_t e;
        int bc, da;
        issue(rand_vec(255), '0, 8'd1, 4'h7);
        wait_done(bc, da);
        e = sb.pop_front();
        n_checks++; if (Result !== '0 || Result !== e.res) begin n_fail++; $display("FAIL m1_result: got %h want %h", Result, e.res); end
        @(posedge clk);
        issue(rand_vec(255), rand_vec(255), 8'd0, 4'h8);
        wait_done(bc, da);
        e = sb.pop_front();
        n_checks++; if (da !== 9) begin n_fail++; $display("FAIL m0_latency: got %0d want 9", da); end
        n_checks++; if (Result !== '0) begin n_fail++; $display("FAIL m0_result: got %h want 0", Result); end
`ifdef VMM_ERR_CHECK_EN
        n_checks++; if (LaneErr !== 6'b111111) begin n_fail++; $display("FAIL m0_laneerr: got %b want 111111", LaneErr); end
`endif
        @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int bc, da, dcount;
        A = rand_vec(255); B = rand_vec(199); M = 8'd200; WA3In = 4'hC; start = 1'b1;
        @(negedge clk);
        repeat (3) @(posedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (Result !== '0) begin n_fail++; $display("FAIL midrst_result: got %h want 0", Result); end
        n_checks++; if (WA3Out !== 4'h0) begin n_fail++; $display("FAIL midrst_wa3: got %h want 0", WA3Out); end
        @(posedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int j = 0; j < 15; j++) begin
            @(posedge clk);
            if (done) dcount++;
        end
        n_checks++; if (dcount !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dcount); end
        issue(rand_vec(255), rand_vec(199), 8'd200, 4'hD);
        wait_done(bc, da);
        e = sb.pop_front();
        n_checks++; if (da !== 9) begin n_fail++; $display("FAIL midrst_relatency: got %0d want 9", da); end
        n_checks++; if (Result !== e.res) begin n_fail++; $display("FAIL midrst_reresult: got %h want %h", Result, e.res); end
        @(posedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        int d1, d2, dcount;
        d1 = -1; d2 = -1; dcount = 0;
        issue(rand_vec(255), rand_vec(12), 8'd13, 4'h5);
        @(negedge clk);
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            if (j == 1) issue(rand_vec(255), rand_vec(250), 8'd251, 4'h6);
            if (done) dcount++;
            if (done && d1 < 0) begin
                d1 = j;
                e1 = sb.pop_front();
                n_checks++; if (Result !== e1.res) begin n_fail++; $display("FAIL b2b_first: got %h want %h", Result, e1.res); end
            end else if (d1 > 0 && j == d1 + 1) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
            end else if (d1 > 0 && j == d1 + 5) begin
                n_checks++; if (Result !== e1.res) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", Result, e1.res); end
                n_checks++; if (WA3Out !== e1.tag) begin n_fail++; $display("FAIL b2b_hold_wa3: got %h want %h", WA3Out, e1.tag); end
            end else if (done) begin
                d2 = j;
                e2 = sb.pop_front();
                n_checks++; if (Result !== e2.res) begin n_fail++; $display("FAIL b2b_second: got %h want %h", Result, e2.res); end
                n_checks++; if (WA3Out !== e2.tag) begin n_fail++; $display("FAIL b2b_second_wa3: got %h want %h", WA3Out, e2.tag); end
                break;
            end
        end
        start = 1'b0;
        n_checks++; if (d1 !== 9) begin n_fail++; $display("FAIL b2b_d1: got %0d want 9", d1); end
        n_checks++; if (d2 !== 19) begin n_fail++; $display("FAIL b2b_d2: got %0d want 19", d2); end
        n_checks++; if (dcount !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", dcount); end
        @(posedge clk);
    endtask

`ifdef VMM_ERR_CHECK_EN
    task automatic test_lane_err();
        logic [R-1:0][N-1:0] b;
        exp_t e;
        int bc, da;
        b = rand_vec(12);
        b[2] = 8'd20;
        issue(rand_vec(255), b, 8'd13, 4'h9);
        wait_done(bc, da);
        e = sb.pop_front();
        n_checks++; if (LaneErr !== 6'b000100) begin n_fail++; $display("FAIL err_laneerr: got %b want 000100", LaneErr); end
        n_checks++; if (Result[2] !== 8'd0) begin n_fail++; $display("FAIL err_l2: got %0d want 0", Result[2]); end
        n_checks++; if (Result !== e.res) begin n_fail++; $display("FAIL err_result: got %h want %h", Result, e.res); end
        @(posedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_modulus();
        test_reset_mid_run();
        test_back_to_back();
`ifdef VMM_ERR_CHECK_EN
        test_lane_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_modmul_unit.md
Name: vec_modmul_unit

Overview:
- Multi-cycle consumer of the ID/EX bundle for the RSA vector pipeline.
- Accepts R-lane vector operands and one modulus.
- Computes per-lane (A*B) mod M by interleaved shift-add-reduce, MSB first, one bit per cycle, all lanes in parallel.
- Holds the pipeline with a stall while running, then presents results and the writeback tag for one cycle.

Parameters:
N, 8, lane width in bits (operand, modulus, result)
R, 6, number of vector lanes

Ports:
clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers
reset  in  1  asynchronous, active-high reset
start  in  1  issue strobe from EX decode; sampled only in IDLE
A  in  R*N  multiplier lanes, packed [R-1:0][N-1:0]
B  in  R*N  multiplicand lanes, packed [R-1:0][N-1:0]; precondition B[i] < M
M  in  N  modulus, shared by all lanes
WA3In  in  4  destination register tag
busy  out  1  stall request to IF/ID and ID/EX; high in RUN
done  out  1  one-cycle result-valid pulse, high in DONE
Result  out  R*N  per-lane (A*B) mod M; stable from DONE until the next accepted start
WA3Out  out  4  latched destination tag
RegWriteOut  out  1  equals done; writeback enable

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, RegWriteOut=0, Result=0, WA3Out=0, bit counter=0, accumulators=0. Reset mid-RUN discards the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a negedge:
  - latch A, B, M, WA3In
  - clear lane accumulators P[i] (N+2 bits)
  - counter=N-1; go to RUN
- IDLE, start=0: stay.
- RUN, each negedge, per lane:
  - P = 2P
  - if A[i][counter] then P = P + B[i]
  - if P >= M then P = P - M
  - if P >= M then P = P - M
  - Arithmetic uses N+2 bits. No overflow because P < M and B < M hold before each step.
- RUN counter control: if counter==0, go to DONE and load Result[i]=P[i][N-1:0]; else decrement counter.
- DONE: done=1, RegWriteOut=1, busy=0. Next negedge: IDLE.
- start outside IDLE: ignored. EX control holds start until busy falls and done has passed.
- Latency: start sampled at edge k → RUN during edges k+1..k+N → done high for the cycle after edge k+N. Issue-to-issue interval is N+2 cycles.
- M==0: RUN still takes N cycles; all Result lanes forced to 0 at DONE.
- M==1: all lanes 0 (falls out of the algorithm).
- A[i]==0 or B[i]==0: lane result 0.
- Result and WA3Out hold their last values through IDLE. They are overwritten only at the next DONE; they are not cleared at start.

Optional Feature:
- Macro: VMM_ERR_CHECK_EN.
- With the macro defined:
  - adds output LaneErr [R-1:0], reset 0
  - LaneErr[i] is set at start acceptance if M==0 or B[i] >= M
  - LaneErr is valid in DONE and held like Result
  - errored lanes force Result[i]=0
- Without the macro: no port; B >= M gives an unspecified lane result; M==0 still gives 0.

Decomposition:
- Package vmm_pkg:
  - state enum {IDLE, RUN, DONE}
  - accumulator width constant ACC_W = N+2, as a function of N
  - counter width $clog2(N)
- Sub-module vmm_lane, generated R times:
  - holds P and performs one shift-add-reduce step per enable
  - inputs: clr, en, abit, b, m; output: p
- Top holds the FSM, counter, operand/tag latches and result register.

Test Plan:
- Reset during RUN at cycle 3 → busy=0 next instant, no done pulse; a new start then completes normally in N+2 cycles.
- Lane 0: A=7, B=5, M=13 → Result[0]=9; done high exactly 9 cycles after the start edge (N=8), busy high 8 cycles, WA3Out equals WA3In latched at start.
- Lanes: A=255, B=200, M=251 → 47; A=0, B=9, M=251 → 0; A=250, B=250, M=251 → 1, all in the same issue.
- M=1 with arbitrary A/B → all lanes 0. M=0 → all lanes 0, and with VMM_ERR_CHECK_EN LaneErr=6'b111111.
- start held high through RUN and DONE → exactly one operation per IDLE acceptance; the second issue begins only after returning to IDLE, and the first Result holds until the second DONE.
- With VMM_ERR_CHECK_EN: B[2]=20, M=13 → LaneErr=6'b000100 and Result[2]=0; other lanes correct.
